// File: rtl/button_conditioner_if.sv
// button_conditioner_if: press-event bus from the button conditioner to gameplay logic.
// Signals:
//   held        debounced button levels {D,U,L,M,R}, bit0 = R
//   press_valid one-cycle pulse for an accepted single press
//   press_code  1=R 2=M 3=L 4=U 5=D while press_valid, else 0
//   multi_err   one-cycle pulse when more than one button is held
// Modports: master drives the bus (conditioner), slave consumes it.
interface button_conditioner_if;
    logic [4:0] held;
    logic       press_valid;
    logic [2:0] press_code;
    logic       multi_err;
    modport master(output held, press_valid, press_code, multi_err);
    modport slave(input held, press_valid, press_code, multi_err);
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and arbitrate five game buttons into single press events.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   btnR/btnM/btnL/btnU/btnD raw asynchronous button inputs
//   bus (master)             held levels, press_valid/press_code, multi_err
// Optional feature: define BUTTON_AUTO_REPEAT_EN to re-emit the press every
// REPEAT_CYCLES cycles while a single button stays held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btnR,
    input  logic btnM,
    input  logic btnL,
    input  logic btnU,
    input  logic btnD,
    button_conditioner_if.master bus
);
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, LOCKOUT} state_t;

    logic [4:0]       raw, s1, sync, held;
    logic [CNT_W-1:0] cnt [5];
    logic [2:0]       ones;
    logic             none, single, multi;
    state_t           state, state_n;
    logic             press_valid_n, multi_err_n, press_valid_r, multi_err_r;
    logic [2:0]       press_code_n, press_code_r;
    logic             rep_fire;
    logic [2:0]       last_code;

    function automatic logic [2:0] enc(input logic [4:0] h);
        return h[0] ? 3'd1 : h[1] ? 3'd2 : h[2] ? 3'd3 : h[3] ? 3'd4 : h[4] ? 3'd5 : 3'd0;
    endfunction

    assign raw = {btnD, btnU, btnL, btnM, btnR};

    // Two-flop synchroniser followed by an independent debounce counter per button.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            sync <= '0;
            held <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            s1   <= raw;
            sync <= s1;
            for (int i = 0; i < 5; i++) begin
                if (sync[i] == held[i]) cnt[i] <= '0;
                else if (cnt[i] == DB_MAX) begin
                    held[i] <= sync[i];
                    cnt[i]  <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign ones   = 3'($countones(held));
    assign none   = held == 5'd0;
    assign single = ones == 3'd1;
    assign multi  = ones > 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            press_valid_r <= 1'b0;
            press_code_r  <= 3'd0;
            multi_err_r   <= 1'b0;
        end else begin
            state         <= state_n;
            press_valid_r <= press_valid_n;
            press_code_r  <= press_code_n;
            multi_err_r   <= multi_err_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = multi ? LOCKOUT : single ? PRESSED : IDLE;
            PRESSED: state_n = none ? IDLE : multi ? LOCKOUT : PRESSED;
            LOCKOUT: state_n = none ? IDLE : LOCKOUT;
            default: state_n = IDLE;
        endcase
    end

    // Events are decided from the current held pattern and registered, so they
    // appear one cycle after held changes. single and multi are exclusive, which
    // keeps press_valid and multi_err from ever coinciding.
    always_comb begin
        press_valid_n = (state == IDLE && single) || rep_fire;
        press_code_n  = (state == IDLE && single) ? enc(held) : rep_fire ? last_code : 3'd0;
        multi_err_n   = state != LOCKOUT && multi;
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    logic [RW-1:0] rep;

    assign rep_fire = state == PRESSED && single && rep == RW'(REPEAT_CYCLES - 1);

    // rep is 0 in the first PRESSED cycle and wraps on each repeat.
    always_ff @(posedge clk) begin
        if (rst || state != PRESSED || state_n != PRESSED || rep_fire) rep <= '0;
        else rep <= rep + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) last_code <= 3'd0;
        else if (state == IDLE && single) last_code <= enc(held);
    end
`else
    assign rep_fire  = 1'b0;
    assign last_code = 3'd0;
`endif

    assign bus.held        = held;
    assign bus.press_valid = press_valid_r;
    assign bus.press_code  = press_code_r;
    assign bus.multi_err   = multi_err_r;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8).
// Stimulus pushes expected events with their cycle; a negedge monitor pops and compares.
module tb_button_conditioner;
    typedef struct {
        bit         is_err;
        logic [2:0] code;
        int         at;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btnR = 1'b0, btnM = 1'b0, btnL = 1'b0, btnU = 1'b0, btnD = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    ev_t  q[$];

    button_conditioner_if bus();

    button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16), .REPEAT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .btnR(btnR), .btnM(btnM), .btnL(btnL), .btnU(btnU), .btnD(btnD),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit is_err, input logic [2:0] code, input int at);
        ev_t e;
        e.is_err = is_err;
        e.code   = code;
        e.at     = at;
        q.push_back(e);
    endtask

    task automatic go(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every event must match the head of the scoreboard in kind, code and cycle.
    always @(negedge clk) begin
        checks++;
        if (bus.press_valid && bus.multi_err) begin
            errors++;
            $display("FAIL exclusive: press_valid and multi_err both high at cyc %0d", cyc);
        end
        checks++;
        if (!bus.press_valid && bus.press_code != 3'd0) begin
            errors++;
            $display("FAIL code_idle: press_code=%0d while press_valid=0, expected 0 at cyc %0d", bus.press_code, cyc);
        end
        if (bus.press_valid || bus.multi_err) begin
            ev_t e;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: pv=%b err=%b code=%0d at cyc %0d, expected none",
                         bus.press_valid, bus.multi_err, bus.press_code, cyc);
            end else begin
                e = q.pop_front();
                if (bus.multi_err != e.is_err || bus.press_code != e.code || cyc != e.at) begin
                    errors++;
                    $display("FAIL event: got err=%b code=%0d cyc=%0d, expected err=%b code=%0d cyc=%0d",
                             bus.multi_err, bus.press_code, cyc, e.is_err, e.code, e.at);
                end
            end
        end
    end

    initial begin
        int c;
        repeat (3) @(negedge clk);
        chk("reset_held", 32'(bus.held), 0);
        chk("reset_pv", 32'(bus.press_valid), 0);
        chk("reset_code", 32'(bus.press_code), 0);
        chk("reset_err", 32'(bus.multi_err), 0);
        rst = 1'b0;
        go(cyc + 3);

        // Clean press on U: held at +6, press at +7.
        c = cyc;
        btnU = 1'b1;
        push(0, 3'd4, c + 7);
`ifdef BUTTON_AUTO_REPEAT_EN
        push(0, 3'd4, c + 15);
        push(0, 3'd4, c + 23);
`endif
        go(c + 5);
        chk("clean_held_before", 32'(bus.held), 0);
        go(c + 6);
        chk("clean_held_rise", 32'(bus.held), 32'h08);
        go(c + 20);
        btnU = 1'b0;
        go(c + 35);
        chk("clean_released", 32'(bus.held), 0);

        // Bounce is rejected, then a solid press on R.
        c = cyc;
        btnR = 1'b1;
        go(c + 1); btnR = 1'b0;
        go(c + 2); btnR = 1'b1;
        go(c + 3); btnR = 1'b0;
        go(c + 15);
        chk("bounce_held", 32'(bus.held), 0);
        c = cyc;
        btnR = 1'b1;
        push(0, 3'd1, c + 7);
        go(c + 10);
        btnR = 1'b0;
        go(c + 25);

        // Simultaneous L and D: one multi_err, then M presses normally.
        c = cyc;
        btnL = 1'b1;
        btnD = 1'b1;
        push(1, 3'd0, c + 7);
        go(c + 6);
        chk("simul_held", 32'(bus.held), 32'h14);
        go(c + 12);
        btnL = 1'b0;
        btnD = 1'b0;
        go(c + 25);
        c = cyc;
        btnM = 1'b1;
        push(0, 3'd2, c + 7);
        go(c + 10);
        btnM = 1'b0;
        go(c + 25);

        // Second button during a press, then partial and full release.
        c = cyc;
        btnM = 1'b1;
        push(0, 3'd2, c + 7);
        go(c + 10);
        btnR = 1'b1;
        push(1, 3'd0, c + 17);
        go(c + 20);
        btnR = 1'b0;
        go(c + 30);
        chk("second_partial_held", 32'(bus.held), 32'h02);
        btnM = 1'b0;
        go(c + 45);
        chk("second_released", 32'(bus.held), 0);
        c = cyc;
        btnL = 1'b1;
        push(0, 3'd3, c + 7);
        go(c + 10);
        btnL = 1'b0;
        go(c + 25);

        // Reset mid-press: the aborted press restarts from the synchroniser.
        c = cyc;
        btnD = 1'b1;
        go(c + 4);
        rst = 1'b1;
        go(c + 5);
        rst = 1'b0;
        chk("rst_mid_held", 32'(bus.held), 0);
        push(0, 3'd5, c + 12);
        go(c + 11);
        chk("rst_mid_held_rise", 32'(bus.held), 32'h10);
        go(c + 20);
        btnD = 1'b0;
        go(c + 35);

        // U held 30 cycles past its press.
        c = cyc;
        btnU = 1'b1;
        push(0, 3'd4, c + 7);
`ifdef BUTTON_AUTO_REPEAT_EN
        push(0, 3'd4, c + 15);
        push(0, 3'd4, c + 23);
        push(0, 3'd4, c + 31);
`endif
        go(c + 31);
        btnU = 1'b0;
        go(c + 50);

        chk("missing_events", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input front end for the five-button game controls (btnR, btnM, btnL, btnU, btnD); sits directly upstream of gameplay input verification.
- Synchronises and debounces each raw button and enforces one-button-at-a-time.
- Emits exactly one single-cycle press event per physical press, so verification logic never needs its own press/release tracking.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debounced level changes (board build uses 50000); must be >= 1.
- CNT_W, 16, width of each debounce counter; must hold DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 8, auto-repeat period in cycles; used only with AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- btnR  in  1  raw right button, asynchronous
- btnM  in  1  raw middle button, asynchronous
- btnL  in  1  raw left button, asynchronous
- btnU  in  1  raw up button, asynchronous
- btnD  in  1  raw down button, asynchronous
- held  out  5  debounced levels {D,U,L,M,R}, bit0 = R
- press_valid  out  1  one-cycle pulse: accepted single press
- press_code  out  3  valid with press_valid: 1=R, 2=M, 3=L, 4=U, 5=D; 0 otherwise
- multi_err  out  1  one-cycle pulse: more than one debounced button high

Behaviour:
Reset:
- rst is sampled on posedge clk only. While high: sync flops, held, counters, press_valid, press_code and multi_err all clear to 0; FSM goes to IDLE.
- A rst asserted mid-press aborts it. No event is emitted for that press.
- A button still physically held after rst deasserts must rise through the debouncer again. It then produces one normal press.

Synchroniser:
- Two flops per button.
- sync[i] reflects the raw input 2 cycles after it is sampled.

Debounce (per button, independent):
- Counter cnt[i] is cleared whenever sync[i] == held[i].
- Otherwise cnt[i] increments each cycle.
- When cnt[i] reaches DEBOUNCE_CYCLES-1 while still differing: held[i] <= sync[i] and cnt[i] <= 0.
- Any glitch that returns sync[i] to held[i] before then clears the counter.
- Latency: raw edge sampled at cycle 0 -> held[i] changes at cycle 2+DEBOUNCE_CYCLES.

Press FSM (reads held, registered outputs):
- IDLE (held == 0):
  - Exactly one held bit set -> next cycle press_valid=1, press_code=that button; go PRESSED.
  - More than one bit set in the same cycle -> multi_err=1, no press_valid; go LOCKOUT.
- PRESSED:
  - held == 0 -> IDLE.
  - Popcount(held) > 1 -> multi_err=1 once; go LOCKOUT.
  - Otherwise stay; no further events.
- LOCKOUT:
  - Stay until held == 0, then IDLE.
  - No press_valid and no further multi_err while here.
- Event outputs:
  - press_valid and multi_err are never high in the same cycle.
  - Each is high for exactly one cycle per event.
  - press_code is 0 whenever press_valid is 0.
- A re-press needs full release to held == 0 first, so there are no double events from bounce.
- The release-to-press gap may be a single cycle of held == 0; that still counts as IDLE.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined:
  - In PRESSED with a single button held, a repeat counter starts at 0 on entry.
  - Every REPEAT_CYCLES cycles it re-emits press_valid with the same press_code.
  - The counter clears on leaving PRESSED and on rst.
  - No repeat in LOCKOUT.
- Undefined:
  - No repeat counter is synthesised.
  - Exactly one press_valid per press, as above.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8):
- Clean press: btnU high at cycle 10, held 20 cycles -> held[3] rises at cycle 16; press_valid=1, press_code=4 at cycle 17 only; nothing further until release.
- Bounce reject: btnR toggles 1,0,1,0 each cycle, then stays 0 -> held stays 0, no press_valid; then btnR held 10 cycles -> exactly one press_valid, code 1.
- Simultaneous: btnL and btnD rise in the same cycle -> one multi_err pulse, zero press_valid; after both released and debounced, btnM press -> press_valid, code 2.
- Second button during press: btnM held, press_valid code 2; btnR added 10 cycles later -> one multi_err; releasing btnR while btnM is still held -> no event; releasing all -> IDLE.
- Reset mid-press: btnD high, rst pulsed at cycle 4 after the sampled edge (before debounce completes), btnD kept high -> no event before rst; exactly one press_valid, code 5, 2+DEBOUNCE_CYCLES+1 cycles after rst deasserts.
- Auto-repeat (macro defined): btnU held 30 cycles after initial press_valid -> additional press_valid code 4 every 8 cycles (3 repeats); macro undefined -> only the initial pulse.
